// File: rtl/periph_pkg.sv
// Shared register map, CTRL field layout and helpers
// for the memory-mapped timer peripherals.
package periph_pkg;

  localparam logic [3:0] TH_OFS   = 4'h0;
  localparam logic [3:0] TL_OFS   = 4'h4;
  localparam logic [3:0] CTRL_OFS = 4'h8;
  localparam logic [3:0] STAT_OFS = 4'hC;
  localparam int CH_STRIDE = 16;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IE     = 1;
  localparam int CTRL_OS     = 2;
  localparam int CTRL_PS_LSB = 8;
  localparam int CTRL_PS_W   = 8;

  typedef struct packed {
    logic [7:0] ps;
    logic       oneshot;
    logic       ie;
    logic       en;
  } ctrl_t;

  function automatic logic [31:0] ctrl_word(
    input ctrl_t c
  );
    return {16'b0, c.ps, 5'b0,
            c.oneshot, c.ie, c.en};
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: TH/TL/CTRL/STAT registers,
// prescaler, up-counter and overflow handling.
import periph_pkg::*;

module timer_channel #(
  parameter int TW  = 32,
  parameter int PSW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          th_we,
  input  logic          tl_we,
  input  logic          ctrl_we,
  input  logic          stat_we,
  input  logic [TW-1:0] wval,
  input  ctrl_t         cval,
  input  logic          clr,
  output logic [TW-1:0] th,
  output logic [TW-1:0] tl,
  output ctrl_t         ctrl,
  output logic          pend,
  output logic          ovf_pulse
);

  logic [PSW-1:0] pre;
  logic [PSW-1:0] ps;
  logic           tick;
  logic           ovf;

  assign ps   = ctrl.ps[PSW-1:0];
  assign tick = ctrl.en && (pre == ps);
  assign ovf  = tick && (&tl);

  // prescaler: counts 0..PS while enabled, TL write restarts it
  always_ff @(posedge clk) begin
    if (reset)
      pre <= '0;
    else if (tl_we || !ctrl.en || tick)
      pre <= '0;
    else
      pre <= pre + 1'b1;
  end

  // reload register; only sampled at the next reload
  always_ff @(posedge clk) begin
    if (reset)
      th <= '0;
    else if (th_we)
      th <= wval;
  end

  // count register: bus write wins over count and reload
  always_ff @(posedge clk) begin
    if (reset)
      tl <= '0;
    else if (tl_we)
      tl <= wval;
    else if (ovf)
      tl <= th;
    else if (tick)
      tl <= tl + 1'b1;
  end

  // control: bus write wins over the one-shot auto-disable
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl <= '0;
    end else if (ctrl_we) begin
      ctrl.en      <= cval.en;
      ctrl.ie      <= cval.ie;
      ctrl.oneshot <= cval.oneshot;
      ctrl.ps      <= 8'(cval.ps[PSW-1:0]);
    end else if (ovf && ctrl.oneshot) begin
      ctrl.en <= 1'b0;
    end
  end

  // pending flag: an overflow is never lost to a same-edge clear
  always_ff @(posedge clk) begin
    if (reset)
      pend <= 1'b0;
    else if (ovf)
      pend <= 1'b1;
    else if (stat_we && clr)
      pend <= 1'b0;
  end

  // one-cycle overflow strobe
  always_ff @(posedge clk) begin
    if (reset)
      ovf_pulse <= 1'b0;
    else
      ovf_pulse <= ovf;
  end

endmodule

// File: rtl/timer_array.sv
// Multi-channel timer: address decode, read mux,
// interrupt summary and combined irqout.
import periph_pkg::*;

module timer_array #(
  parameter logic [31:0] BASE_ADDR = 32'h40000100,
  parameter int N_TIMERS = 4,
  parameter int TW       = 32,
  parameter int PSW      = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rd,
  input  logic                wr,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic                irqout,
  output logic [N_TIMERS-1:0] ovf_pulse
);

  localparam logic [31:0] SUM_OFS =
    32'(CH_STRIDE * N_TIMERS);

  logic [31:0] off;
  logic        in_ch;
  logic        sum_hit;
  logic [2:0]  sel;
  logic [3:0]  ro;
  ctrl_t       cval;

  logic [TW-1:0]       th   [N_TIMERS];
  logic [TW-1:0]       tl   [N_TIMERS];
  ctrl_t               ctrl [N_TIMERS];
  logic [N_TIMERS-1:0] pend;
  logic [N_TIMERS-1:0] ie;
  logic [N_TIMERS-1:0] irq_vec;

  assign off     = addr - BASE_ADDR;
  assign in_ch   = (off[1:0] == 2'b00) &&
                   (off < SUM_OFS);
  assign sum_hit = (off == SUM_OFS);
  assign sel     = off[6:4];
  assign ro      = off[3:0];

  assign cval.en      = wdata[CTRL_EN];
  assign cval.ie      = wdata[CTRL_IE];
  assign cval.oneshot = wdata[CTRL_OS];
  assign cval.ps      =
    wdata[CTRL_PS_LSB +: CTRL_PS_W];

  for (genvar g = 0; g < N_TIMERS; g++) begin : g_ch
    logic hit;
    assign hit   = wr && in_ch && (sel == 3'(g));
    assign ie[g] = ctrl[g].ie;

    timer_channel #(
      .TW  (TW),
      .PSW (PSW)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .th_we     (hit && (ro == TH_OFS)),
      .tl_we     (hit && (ro == TL_OFS)),
      .ctrl_we   (hit && (ro == CTRL_OFS)),
      .stat_we   (hit && (ro == STAT_OFS)),
      .wval      (wdata[TW-1:0]),
      .cval      (cval),
      .clr       (wdata[0]),
      .th        (th[g]),
      .tl        (tl[g]),
      .ctrl      (ctrl[g]),
      .pend      (pend[g]),
      .ovf_pulse (ovf_pulse[g])
    );
  end

  assign irq_vec = pend & ie;
  assign irqout  = |irq_vec;

  // read mux: zero unless a mapped register is read
  always_comb begin
    rdata = '0;
    if (rd && sum_hit) begin
      rdata = 32'(irq_vec);
    end else if (rd && in_ch) begin
      for (int i = 0; i < N_TIMERS; i++) begin
        if (sel == 3'(i)) begin
          case (ro)
            TH_OFS:   rdata = 32'(th[i]);
            TL_OFS:   rdata = 32'(tl[i]);
            CTRL_OFS: rdata = ctrl_word(ctrl[i]);
            STAT_OFS: rdata = {31'b0, pend[i]};
            default:  rdata = '0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_array.sv
// Directed bench for timer_array: register table
// plus multi-cycle overflow / precedence sequences.
module tb_timer_array;

  localparam logic [31:0] B = 32'h40000100;

  logic        clk;
  logic        reset;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irqout;
  logic [3:0]  ovf_pulse;

  int ncmp;
  int nbad;

  timer_array dut (
    .clk       (clk),
    .reset     (reset),
    .rd        (rd),
    .wr        (wr),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .irqout    (irqout),
    .ovf_pulse (ovf_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        do_wr;
    logic [31:0] waddr;
    logic [31:0] wdat;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t tv [16];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  task automatic wr_reg(input logic [31:0] a,
                        input logic [31:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    @(posedge clk);
    #1;
    wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [31:0] a,
                        output logic [31:0] d);
    @(negedge clk);
    addr = a;
    rd   = 1'b1;
    #1;
    d  = rdata;
    rd = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic [31:0] v;
  logic [31:0] e;

  initial begin
    ncmp  = 0;
    nbad  = 0;
    clk   = 1'b0;
    reset = 1'b1;
    rd    = 1'b0;
    wr    = 1'b0;
    addr  = '0;
    wdata = '0;

    tv[0]  = '{"rst_th0",   0, 0, 0, B+'h00, 0};
    tv[1]  = '{"rst_tl0",   0, 0, 0, B+'h04, 0};
    tv[2]  = '{"rst_ctrl0", 0, 0, 0, B+'h08, 0};
    tv[3]  = '{"rst_stat0", 0, 0, 0, B+'h0C, 0};
    tv[4]  = '{"rst_th3",   0, 0, 0, B+'h30, 0};
    tv[5]  = '{"rst_stat3", 0, 0, 0, B+'h3C, 0};
    tv[6]  = '{"rst_sum",   0, 0, 0, B+'h40, 0};
    tv[7]  = '{"unm_hi",    0, 0, 0, B+'h44, 0};
    tv[8]  = '{"unm_lo",    0, 0, 0, B-4,    0};
    tv[9]  = '{"rw_th1", 1, B+'h10, 32'h12345678,
               B+'h10, 32'h12345678};
    tv[10] = '{"rw_tl2", 1, B+'h24, 32'hDEADBEEF,
               B+'h24, 32'hDEADBEEF};
    tv[11] = '{"rw_ctrl2", 1, B+'h28, 32'hFFFFFF06,
               B+'h28, 32'h0000FF06};
    tv[12] = '{"wr_sum_ign", 1, B+'h40, 32'hF,
               B+'h40, 0};
    tv[13] = '{"w1c_idle", 1, B+'h2C, 32'h1,
               B+'h2C, 0};
    tv[14] = '{"unm_wr_ign", 1, B+'h50, 32'hAAAAAAAA,
               B+'h10, 32'h12345678};
    tv[15] = '{"rw_tl1", 1, B+'h14, 32'h77,
               B+'h14, 32'h77};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    @(negedge clk);
    addr = B + 'h24;
    #1;
    chk("rd_low", rdata, 0);
    chk("rst_irq", {31'b0, irqout}, 0);
    chk("rst_ovf", {28'b0, ovf_pulse}, 0);

    for (int i = 0; i < 16; i++) begin
      if (tv[i].do_wr)
        wr_reg(tv[i].waddr, tv[i].wdat);
      rd_reg(tv[i].raddr, v);
      chk(tv[i].name, v, tv[i].exp);
    end

    do_reset();

    // ch0 auto-reload, period 4
    wr_reg(B+'h00, 32'hFFFFFFFC);
    wr_reg(B+'h04, 32'hFFFFFFFC);
    wr_reg(B+'h08, 32'h3);
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      addr = B + 'h04;
      rd   = 1'b1;
      #1;
      e = 32'hFFFFFFFC + 32'(j % 4);
      chk("ch0_tl", rdata, e);
      chk("ch0_ovf", {31'b0, ovf_pulse[0]},
          {31'b0, (j % 4 == 0) && (j > 0)});
      rd = 1'b0;
    end
    rd_reg(B+'h0C, v);
    chk("ch0_pend", v, 1);
    chk("ch0_irq", {31'b0, irqout}, 1);
    rd_reg(B+'h40, v);
    chk("ch0_sum", v, 1);
    wr_reg(B+'h08, 32'h2);
    @(negedge clk);
    chk("ch0_irq_hold", {31'b0, irqout}, 1);
    wr_reg(B+'h0C, 32'h1);
    @(negedge clk);
    chk("ch0_irq_clr", {31'b0, irqout}, 0);

    // ch1 one-shot, PS=3
    wr_reg(B+'h10, 32'h10);
    wr_reg(B+'h14, 32'hFFFFFFFE);
    wr_reg(B+'h18, 32'h305);
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      addr = B + 'h14;
      rd   = 1'b1;
      #1;
      e = (j < 4) ? 32'hFFFFFFFE :
          (j < 8) ? 32'hFFFFFFFF : 32'h10;
      chk("ch1_tl", rdata, e);
      chk("ch1_ovf", {31'b0, ovf_pulse[1]},
          {31'b0, j == 8});
      rd = 1'b0;
    end
    rd_reg(B+'h18, v);
    chk("ch1_ctrl", v, 32'h304);
    rd_reg(B+'h1C, v);
    chk("ch1_pend", v, 1);
    chk("ch1_irq", {31'b0, irqout}, 0);
    rd_reg(B+'h40, v);
    chk("ch1_sum", v, 0);

    // overflow and W1C on the same edge
    wr_reg(B+'h00, 32'h0);
    wr_reg(B+'h04, 32'hFFFFFFFF);
    wr_reg(B+'h08, 32'h1);
    wr_reg(B+'h0C, 32'h1);
    rd_reg(B+'h0C, v);
    chk("ovf_vs_w1c", v, 1);
    wr_reg(B+'h08, 32'h0);

    // TL write on the overflow edge
    wr_reg(B+'h30, 32'h55);
    wr_reg(B+'h34, 32'hFFFFFFFF);
    wr_reg(B+'h38, 32'h1);
    wr_reg(B+'h34, 32'h1234);
    rd_reg(B+'h34, v);
    chk("tl_vs_ovf", v, 32'h1234);
    wr_reg(B+'h38, 32'h0);

    // all channels, IE only on ch2
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr_reg(B + 32'(16*i), 32'hFFFFFFFE);
      wr_reg(B + 32'(16*i) + 4, 32'hFFFFFFFE);
      wr_reg(B + 32'(16*i) + 8,
             32'((i << 8) | 1 | ((i == 2) ? 2 : 0)));
    end
    rd_reg(B+'h40, v);
    chk("all_sum0", v, 0);
    chk("all_irq0", {31'b0, irqout}, 0);
    repeat (40) @(posedge clk);
    rd_reg(B+'h40, v);
    chk("all_sum", v, 32'h4);
    chk("all_irq", {31'b0, irqout}, 1);
    rd_reg(B+'h0C, v);
    chk("all_pend0", v, 1);
    wr_reg(B+'h28, 32'h201);
    @(negedge clk);
    chk("ie2_off_irq", {31'b0, irqout}, 0);
    rd_reg(B+'h40, v);
    chk("ie2_off_sum", v, 0);
    wr_reg(B+'h28, 32'h203);
    @(negedge clk);
    chk("ie2_on_irq", {31'b0, irqout}, 1);

    // reset mid-count
    do_reset();
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk("mid_rst_ovf", {28'b0, ovf_pulse}, 0);
      chk("mid_rst_irq", {31'b0, irqout}, 0);
    end
    rd_reg(B+'h04, v);
    chk("mid_rst_tl0", v, 0);
    rd_reg(B+'h28, v);
    chk("mid_rst_ctrl2", v, 0);
    rd_reg(B+'h2C, v);
    chk("mid_rst_pend2", v, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

endmodule
